// File: rtl/ebus_pkg.sv
// ebus_pkg: shared EBUS types, the diagnostic sequencer state encoding and
// the named diagnostic function codes used by the console side.
// Bit numbering follows the PDP-10 convention: bit 0 is the most significant.
package ebus_pkg;

    typedef logic [0:35] tEBUSdata;
    typedef logic [0:6]  tDiagFunc;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        DONE
    } state_e;

    localparam tDiagFunc DIAG_READ_APR  = 7'o12;
    localparam tDiagFunc DIAG_WRITE_CTL = 7'o42;
    localparam tDiagFunc DIAG_READ_SCD  = 7'o14;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ebus_diag_seq.sv
// ebus_diag_seq: DTE-side EBUS diagnostic-function sequencer.
// Turns one console request (diag read or write) into a timed EBUS cycle:
// setup, strobe, optional wait for a driver, then a held response.
//
// Ports:
//   clk, CROBAR_N               clock, asynchronous active-low reset
//   abort                       synchronous abort back to IDLE, no response
//   req_valid/req_ready         request handshake
//   req_write/req_diag/req_data request contents
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_timeout        read data, read-timed-out flag
//   ebus_data_in                muxed EBUS data (sampled only at capture)
//   ebus_any_driving            OR of every module's driving flag
//   diag_func/diag_read/diag_strobe  diagnostic broadcast to modules
//   drv_driving/drv_data        DTE's own EBUSdriver slot into the data mux
module ebus_diag_seq
    import ebus_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        CROBAR_N,
    input  logic        abort,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [0:6]  req_diag,
    input  logic [0:35] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:35] rsp_data,
    output logic        rsp_timeout,
    input  logic [0:35] ebus_data_in,
    input  logic        ebus_any_driving,
    output logic [0:6]  diag_func,
    output logic        diag_read,
    output logic        diag_strobe,
    output logic        drv_driving,
    output logic [0:35] drv_data
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, TIMEOUT_CYC)) + 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_q, write_d;
    tDiagFunc         diag_q, diag_d;
    tEBUSdata         data_q, data_d;

    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    tEBUSdata         rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    tDiagFunc         diag_func_q, diag_func_d;
    logic             diag_read_q, diag_read_d;
    logic             diag_strobe_q, diag_strobe_d;
    logic             drv_driving_q, drv_driving_d;
    tEBUSdata         drv_data_q, drv_data_d;

    logic             bus_busy;

    // Next-state logic. Every bus output is derived from the next state so
    // that the registered outputs line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        write_d       = write_q;
        diag_d        = diag_q;
        data_d        = data_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    diag_d  = req_diag;
                    data_d  = req_data;
                    count_d = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (count_q == '0) begin
                    count_d = STROBE_LOAD;
                    state_d = STROBE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (count_q == '0) begin
                    // A write ignores ebus_any_driving: our own drv_driving
                    // is part of that OR.
                    if (write_q) begin
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                        state_d       = DONE;
                    end else if (ebus_any_driving) begin
                        rsp_data_d    = ebus_data_in;
                        rsp_timeout_d = 1'b0;
                        state_d       = DONE;
                    end else begin
                        count_d = TIMEOUT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            WAIT: begin
                if (ebus_any_driving) begin
                    rsp_data_d    = ebus_data_in;
                    rsp_timeout_d = 1'b0;
                    state_d       = DONE;
                end else if (count_q == '0) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a request offered in IDLE.
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
            write_d = 1'b0;
            diag_d  = '0;
            data_d  = '0;
        end

        // The response is only visible while DONE is held.
        if (state_d != DONE) begin
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
        end
    end

    // Output decode from the next state.
    always_comb begin
        bus_busy      = (state_d == SETUP) || (state_d == STROBE) || (state_d == WAIT);
        req_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == DONE);
        diag_func_d   = bus_busy ? diag_d : '0;
        diag_read_d   = bus_busy && !write_d;
        diag_strobe_d = (state_d == STROBE);
        drv_driving_d = write_d && ((state_d == SETUP) || (state_d == STROBE));
        drv_data_d    = drv_driving_d ? data_d : '0;
    end

    // State, counter, latched request and registered outputs. Reset drops
    // any bus drive at once.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q       <= IDLE;
            count_q       <= '0;
            write_q       <= 1'b0;
            diag_q        <= '0;
            data_q        <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            diag_func_q   <= '0;
            diag_read_q   <= 1'b0;
            diag_strobe_q <= 1'b0;
            drv_driving_q <= 1'b0;
            drv_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            write_q       <= write_d;
            diag_q        <= diag_d;
            data_q        <= data_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            diag_func_q   <= diag_func_d;
            diag_read_q   <= diag_read_d;
            diag_strobe_q <= diag_strobe_d;
            drv_driving_q <= drv_driving_d;
            drv_data_q    <= drv_data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign diag_func   = diag_func_q;
    assign diag_read   = diag_read_q;
    assign diag_strobe = diag_strobe_q;
    assign drv_driving = drv_driving_q;
    assign drv_data    = drv_data_q;

endmodule

// File: tb/tb_ebus_diag_seq.sv
// tb_ebus_diag_seq: directed and randomized bench for ebus_diag_seq.
// Expected behaviour of each transaction is worked out from the cycle
// timeline (setup, strobe, wait, done) by plain arithmetic.
module tb_ebus_diag_seq;
    import ebus_pkg::*;

    localparam int S  = 2;
    localparam int T  = 2;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        crobarN;
    logic        abort;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    tDiagFunc    req_diag;
    tEBUSdata    req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    tEBUSdata    rsp_data;
    logic        rsp_timeout;
    tEBUSdata    ebus_data_in;
    logic        ebus_any_driving;
    tDiagFunc    diag_func;
    logic        diag_read;
    logic        diag_strobe;
    logic        drv_driving;
    tEBUSdata    drv_data;

    int nChecks = 0;
    int nPass   = 0;

    ebus_diag_seq #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk             (clk),
        .CROBAR_N        (crobarN),
        .abort           (abort),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_diag        (req_diag),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_timeout     (rsp_timeout),
        .ebus_data_in    (ebus_data_in),
        .ebus_any_driving(ebus_any_driving),
        .diag_func       (diag_func),
        .diag_read       (diag_read),
        .diag_strobe     (diag_strobe),
        .drv_driving     (drv_driving),
        .drv_data        (drv_data)
    );

    always #5 clk = ~clk;

    function automatic tEBUSdata rand36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: got %0o want %0o", tag, obs, exp);
    endtask

    // Everything quiet and ready for a request.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " req_ready"},   64'(req_ready),   64'd1);
        checkOutput({tag, " rsp_valid"},   64'(rsp_valid),   64'd0);
        checkOutput({tag, " rsp_data"},    64'(rsp_data),    64'd0);
        checkOutput({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        checkOutput({tag, " diag_func"},   64'(diag_func),   64'd0);
        checkOutput({tag, " diag_read"},   64'(diag_read),   64'd0);
        checkOutput({tag, " diag_strobe"}, 64'(diag_strobe), 64'd0);
        checkOutput({tag, " drv_driving"}, 64'(drv_driving), 64'd0);
        checkOutput({tag, " drv_data"},    64'(drv_data),    64'd0);
    endtask

    // One full transaction. A read driver (if any) starts in cycle drvStart
    // and stays on; cycle 1 is the first cycle after the accepting edge.
    task automatic applyStimulus(input logic wr, input tDiagFunc diag, input tEBUSdata data,
                                 input int drvStart, input tEBUSdata drvData, input int readyDelay);
        int       done;
        int       capAt;
        tEBUSdata expData;
        logic     expTo;
        logic     busy;
        logic     expDrv;
        string    tg;

        capAt   = (drvStart > S + T) ? drvStart : S + T;
        expData = '0;
        expTo   = 1'b0;
        if (wr) begin
            done = S + T + 1;
        end else if (capAt <= S + T + TO) begin
            done    = capAt + 1;
            expData = drvData;
        end else begin
            done  = S + T + TO + 1;
            expTo = 1'b1;
        end

        @(negedge clk);
        checkIdle("pre");
        req_valid        = 1'b1;
        req_write        = wr;
        req_diag         = diag;
        req_data         = data;
        rsp_ready        = 1'($urandom_range(0, 1));
        ebus_any_driving = 1'b0;
        ebus_data_in     = rand36();

        for (int c = 1; c <= done + readyDelay; c++) begin
            @(negedge clk);
            busy   = (c < done);
            expDrv = wr && (c <= S + T);
            tg     = $sformatf("c%0d", c);
            checkOutput({tg, " req_ready"},   64'(req_ready),   64'd0);
            checkOutput({tg, " rsp_valid"},   64'(rsp_valid),   64'(!busy));
            checkOutput({tg, " rsp_data"},    64'(rsp_data),    busy ? 64'd0 : 64'(expData));
            checkOutput({tg, " rsp_timeout"}, 64'(rsp_timeout), busy ? 64'd0 : 64'(expTo));
            checkOutput({tg, " diag_func"},   64'(diag_func),   busy ? 64'(diag) : 64'd0);
            checkOutput({tg, " diag_read"},   64'(diag_read),   64'(busy && !wr));
            checkOutput({tg, " diag_strobe"}, 64'(diag_strobe), 64'((c > S) && (c <= S + T)));
            checkOutput({tg, " drv_driving"}, 64'(drv_driving), 64'(expDrv));
            checkOutput({tg, " drv_data"},    64'(drv_data),    expDrv ? 64'(data) : 64'd0);

            // Requests offered while busy must be ignored.
            req_valid = busy;
            req_write = 1'($urandom_range(0, 1));
            req_diag  = 7'($urandom());
            req_data  = rand36();

            if (!busy) begin
                ebus_any_driving = 1'b0;
                ebus_data_in     = rand36();
            end else if (wr) begin
                ebus_any_driving = 1'($urandom_range(0, 1));
                ebus_data_in     = rand36();
            end else begin
                ebus_any_driving = (c >= drvStart);
                ebus_data_in     = (c >= drvStart && c <= capAt) ? drvData : rand36();
            end

            rsp_ready = busy ? 1'($urandom_range(0, 1)) : (c >= done + readyDelay);
        end

        @(negedge clk);
        checkIdle("post");
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        crobarN          = 1'b0;
        abort            = 1'b0;
        req_valid        = 1'b0;
        req_write        = 1'b0;
        req_diag         = '0;
        req_data         = '0;
        rsp_ready        = 1'b0;
        ebus_data_in     = '0;
        ebus_any_driving = 1'b0;

        #12;
        checkIdle("reset");
        @(negedge clk);
        crobarN = 1'b1;

        // Write, prompt response in cycle 5.
        applyStimulus(1'b1, DIAG_WRITE_CTL, 36'o123456_654321, NEVER, '0, 0);
        // Read with driver during strobe.
        applyStimulus(1'b0, DIAG_READ_APR, '0, 3, 36'o777000_000777, 0);
        // Read, driver appears 3 cycles after strobe ends: response in cycle 9.
        applyStimulus(1'b0, DIAG_READ_APR, '0, S + T + 4, 36'o1, 0);
        // Read timeout: response in cycle 21.
        applyStimulus(1'b0, DIAG_READ_SCD, '0, NEVER, '0, 0);
        // Backpressure: response held for 10 cycles.
        applyStimulus(1'b0, DIAG_READ_APR, '0, 4, 36'o525252_252525, 10);

        // Abort in SETUP.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_diag  = DIAG_READ_SCD;
        @(negedge clk);
        checkOutput("abort setup diag_func", 64'(diag_func), 64'(DIAG_READ_SCD));
        req_valid = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkIdle("abort next");
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort quiet rsp_valid", 64'(rsp_valid), 64'd0);
        end

        // Abort in IDLE together with a request: not accepted.
        req_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        abort     = 1'b0;
        checkIdle("abort idle");

        // Async reset in the middle of a write's strobe.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_diag  = DIAG_WRITE_CTL;
        req_data  = 36'o707070_070707;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst pre diag_strobe", 64'(diag_strobe), 64'd1);
        checkOutput("rst pre drv_driving", 64'(drv_driving), 64'd1);
        #2;
        crobarN = 1'b0;
        #1;
        checkOutput("rst drv_driving", 64'(drv_driving), 64'd0);
        checkOutput("rst diag_strobe", 64'(diag_strobe), 64'd0);
        checkOutput("rst req_ready",   64'(req_ready),   64'd1);
        @(negedge clk);
        crobarN = 1'b1;
        applyStimulus(1'b1, DIAG_WRITE_CTL, 36'o111222_333444, NEVER, '0, 1);

        // Randomized transactions.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom()), rand36(),
                          $urandom_range(1, 24), rand36(), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ebus_diag_seq.md
Name: ebus_diag_seq

Overview:
- DTE-side EBUS diagnostic-function sequencer.
- Turns one console request (diag read or write of a 7-bit diag function) into a timed EBUS cycle: setup, strobe, optional wait for a driver, then capture.
- Downstream of the top-level EBUS data mux. Consumes the muxed EBUS data plus the OR of all module "driving" flags.
- Upstream of that mux for writes. Its write data enters the mux through the DTE EBUSdriver slot.

Parameters:
- SETUP_CYC, 2: cycles diag function/select are stable before strobe (>=1).
- STROBE_CYC, 2: cycles diag strobe is asserted (>=1).
- TIMEOUT_CYC, 16: cycles after strobe a read waits for any driver (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- CROBAR_N  in  1  asynchronous active-low reset; single clock domain.
- abort  in  1  synchronous abort: return to IDLE, no response.
- req_valid  in  1  request offered.
- req_ready  out  1  sequencer can accept.
- req_write  in  1  1 = diag write, 0 = diag read.
- req_diag  in  [0:6]  diag function code.
- req_data  in  [0:35]  write data.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  console accepts response.
- rsp_data  out  [0:35]  read data (0 for writes and timeouts).
- rsp_timeout  out  1  read saw no driver.
- ebus_data_in  in  [0:35]  muxed EBUS data.
- ebus_any_driving  in  1  OR of all EBUSdriver.driving flags.
- diag_func  out  [0:6]  diag function broadcast to modules.
- diag_read  out  1  read cycle in progress (modules may drive).
- diag_strobe  out  1  diag strobe.
- drv_driving  out  1  DTE EBUSdriver.driving.
- drv_data  out  [0:35]  DTE EBUSdriver.data.

Behaviour:
- Reset (async, CROBAR_N=0):
  - State goes to IDLE.
  - All outputs 0 except req_ready=1.
  - Latched request and counter cleared.
  - Reset mid-cycle drops any bus drive immediately, with no response.
- States: IDLE, SETUP, STROBE, WAIT, DONE. A single down-counter, width clog2(max param)+1, times SETUP/STROBE/WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, diag and data; load counter=SETUP_CYC-1; go to SETUP.
  - diag_func=0 in IDLE.
- SETUP:
  - diag_func=latched diag.
  - diag_read=!write.
  - drv_driving=write; drv_data=latched data when write, else 0.
  - Counter decrements; at 0 load STROBE_CYC-1 and go to STROBE.
- STROBE:
  - Same outputs as SETUP, plus diag_strobe=1.
  - At counter 0:
    - Write: go to DONE with rsp_data=0.
    - Read with ebus_any_driving=1 that cycle: capture ebus_data_in, go to DONE.
    - Read otherwise: load TIMEOUT_CYC-1, go to WAIT.
- WAIT (read only):
  - diag_func and diag_read held; diag_strobe=0.
  - First cycle with ebus_any_driving=1: capture ebus_data_in, go to DONE.
  - Counter 0 with no driver: rsp_data=0, rsp_timeout=1, go to DONE.
- DONE:
  - diag_func, diag_read, diag_strobe and drv_driving are all 0.
  - rsp_valid=1 with data/timeout stable until rsp_ready.
  - On rsp_ready go to IDLE. No new request is accepted in the same cycle.
- Latency: accept at edge 0; rsp_valid high in cycle 1+SETUP_CYC+STROBE_CYC (5 with defaults), plus WAIT cycles for late reads.
- Priority:
  - abort beats everything. Any state goes to IDLE next cycle, and outputs clear as in reset.
  - abort in IDLE together with req_valid: request not accepted.
- Other boundary cases:
  - ebus_any_driving during a write is ignored. The DTE's own drv_driving feeds that OR.
  - ebus_data_in is sampled only at the capture point.
  - rsp_ready outside DONE is ignored.
  - req_valid outside IDLE is ignored; req_ready=0.

Decomposition:
- Shared package ebus_pkg:
  - typedef state enum {IDLE, SETUP, STROBE, WAIT, DONE}.
  - typedefs tEBUSdata [0:35] and tDiagFunc [0:6].
  - Named diag function constants used by the bench: DIAG_READ_APR, DIAG_WRITE_CTL, DIAG_READ_SCD.
- No sub-module needed. The FSM plus counter is one module.

Test Plan:
- Write: req_write=1, req_diag=7'o42, req_data=36'o123456_654321 -> req_ready drops next cycle.
  - drv_driving=1 with drv_data=36'o123456654321 for 4 cycles.
  - diag_strobe high for cycles 3–4.
  - rsp_valid in cycle 5, rsp_data=0, rsp_timeout=0.
- Read, prompt driver: req_diag=7'o12; bench asserts ebus_any_driving with ebus_data_in=36'o777000_000777 during strobe -> rsp_data=36'o777000000777 in cycle 5, diag_read=1 for cycles 1–4.
- Read, late driver: driver appears 3 cycles after strobe ends, data 36'o1 -> rsp_valid in cycle 9, rsp_data=1, rsp_timeout=0.
- Read timeout: no driver ever -> WAIT 16 cycles; rsp_valid cycle 21, rsp_data=0, rsp_timeout=1.
- Backpressure/abort:
  - rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout.
  - abort in SETUP -> IDLE next cycle, no rsp_valid, all bus outputs 0.
- Async reset: drop CROBAR_N mid-STROBE of a write -> drv_driving and diag_strobe go 0 immediately, req_ready=1 after release, next request runs normally.
